// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM states and idle code for the ALU operation sequencer.
// Divide support is selected at build time with ALU_SEQ_DIV_EN.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_NAND = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_XNOR = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b0110;
    localparam logic [3:0] OP_ADD  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_DIV  = 4'b1010;

    localparam logic [3:0] CTRL_IDLE = 4'b0000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        ITER = 2'b10,
        DONE = 2'b11
    } state_e;

endpackage

// File: rtl/alu_seq_iter_unit.sv
// Shared shift/add/subtract datapath: shift-add multiply and restoring divide.
// The divide half exists only when ALU_SEQ_DIV_EN is defined.
module alu_seq_iter_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
`ifdef ALU_SEQ_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CW = $clog2(WIDTH + 1);

    // hi_q holds the running high word / remainder, lo_q the multiplier / dividend-quotient
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] mul_hi_s;
    logic [WIDTH-1:0] mul_lo_s;
`ifdef ALU_SEQ_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   rem_s;
    logic [WIDTH:0]   diff_s;
    logic             fits_s;
    logic [WIDTH-1:0] div_hi_s;
    logic [WIDTH-1:0] div_lo_s;
`endif

    // one iteration step: add-and-shift (multiply) or shift-and-subtract (divide)
    always_comb begin
        sum_s = {1'b0, hi_q} + {1'b0, b_q};
        if (lo_q[0]) begin
            mul_hi_s = sum_s[WIDTH:1];
            mul_lo_s = {sum_s[0], lo_q[WIDTH-1:1]};
        end else begin
            mul_hi_s = {1'b0, hi_q[WIDTH-1:1]};
            mul_lo_s = {hi_q[0], lo_q[WIDTH-1:1]};
        end
`ifdef ALU_SEQ_DIV_EN
        rem_s  = {hi_q, lo_q[WIDTH-1]};
        diff_s = rem_s - {1'b0, b_q};
        fits_s = (rem_s >= {1'b0, b_q});
        if (fits_s) begin
            div_hi_s = diff_s[WIDTH-1:0];
        end else begin
            div_hi_s = rem_s[WIDTH-1:0];
        end
        div_lo_s = {lo_q[WIDTH-2:0], fits_s};
        hi_d = div_q ? div_hi_s : mul_hi_s;
        lo_d = div_q ? div_lo_s : mul_lo_s;
`else
        hi_d = mul_hi_s;
        lo_d = mul_lo_s;
`endif
    end

    // operand load on start, then WIDTH iterations; done stays set until the next start
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q   <= {WIDTH{1'b0}};
            lo_q   <= {WIDTH{1'b0}};
            b_q    <= {WIDTH{1'b0}};
            cnt_q  <= {CW{1'b0}};
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_q  <= 1'b0;
`endif
        end else if (start) begin
            hi_q   <= {WIDTH{1'b0}};
            lo_q   <= a;
            b_q    <= b;
            cnt_q  <= CW'(WIDTH);
            busy_q <= 1'b1;
            done_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_q  <= is_div;
`endif
        end else if (busy_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign done   = done_q;
    assign res_lo = lo_q;
    assign res_hi = hi_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU sequencer: valid/ready request in, valid/ready result out.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise opcode 1010 is illegal.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       operation_type,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [3:0]       controller,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry_out,
    output logic             zero,
    output logic             div_by_zero,
    output logic             illegal
);

    state_e           state_q;
    state_e           state_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;

    logic             op_ready_q;
    logic             result_valid_q;
    logic [3:0]       ctrl_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] hi_q;
    logic             cout_q;
    logic             zero_q;
    logic             ill_q;

    logic             accept_s;
    logic             start_s;
    logic             load_s;
    logic             consume_s;
    logic             iter_done_s;
    logic [WIDTH-1:0] iter_lo_s;
    logic [WIDTH-1:0] iter_hi_s;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] hi_d;
    logic             cout_d;
    logic             zero_d;
    logic             ill_d;
`ifdef ALU_SEQ_DIV_EN
    logic             dbz_q;
    logic             dbz_d;
`endif

    assign accept_s  = op_valid & op_ready_q;
    assign consume_s = (state_q == DONE) & result_ready;
    assign load_s    = (state_q == EXEC) | ((state_q == ITER) & iter_done_s);

    // a divide by zero never enters the iterative path; it is resolved in EXEC
`ifdef ALU_SEQ_DIV_EN
    assign start_s = accept_s & ((operation_type == OP_MUL) |
                                 ((operation_type == OP_DIV) & (b != {WIDTH{1'b0}})));
`else
    assign start_s = accept_s & (operation_type == OP_MUL);
`endif

    alu_seq_iter_unit #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clock  (clock),
        .reset  (reset),
        .start  (start_s),
`ifdef ALU_SEQ_DIV_EN
        .is_div (operation_type == OP_DIV),
`endif
        .a      (a),
        .b      (b),
        .done   (iter_done_s),
        .res_lo (iter_lo_s),
        .res_hi (iter_hi_s)
    );

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = start_s ? ITER : EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: state_d = DONE;
            ITER: state_d = iter_done_s ? DONE : ITER;
            DONE: state_d = result_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    // single-cycle results from the captured operands, or the iterative unit's words
    always_comb begin
        add_s  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        sub_s  = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin_q};
        res_d  = {WIDTH{1'b0}};
        hi_d   = {WIDTH{1'b0}};
        cout_d = 1'b0;
        ill_d  = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        dbz_d  = 1'b0;
`endif
        if (state_q == ITER) begin
            res_d = iter_lo_s;
            hi_d  = iter_hi_s;
        end else begin
            case (op_q)
                OP_AND:  res_d = a_q & b_q;
                OP_NAND: res_d = ~(a_q & b_q);
                OP_OR:   res_d = a_q | b_q;
                OP_NOR:  res_d = ~(a_q | b_q);
                OP_XOR:  res_d = a_q ^ b_q;
                OP_XNOR: res_d = ~(a_q ^ b_q);
                OP_NOT:  res_d = ~a_q;
                OP_ADD: begin
                    res_d  = add_s[WIDTH-1:0];
                    cout_d = add_s[WIDTH];
                end
                OP_SUB: begin
                    res_d  = sub_s[WIDTH-1:0];
                    cout_d = ~sub_s[WIDTH];
                end
`ifdef ALU_SEQ_DIV_EN
                OP_DIV: begin
                    res_d = {WIDTH{1'b1}};
                    hi_d  = a_q;
                    dbz_d = 1'b1;
                end
`endif
                default: ill_d = 1'b1;
            endcase
        end
        zero_d = ~|{hi_d, res_d};
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // request capture; later input changes are invisible to the op in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q  <= CTRL_IDLE;
            a_q   <= {WIDTH{1'b0}};
            b_q   <= {WIDTH{1'b0}};
            cin_q <= 1'b0;
        end else if (accept_s) begin
            op_q  <= operation_type;
            a_q   <= a;
            b_q   <= b;
            cin_q <= carry_in;
        end
    end

    // registered outputs, held through DONE and cleared once the result is taken
    always_ff @(posedge clock) begin
        if (reset) begin
            op_ready_q     <= 1'b1;
            result_valid_q <= 1'b0;
            ctrl_q         <= CTRL_IDLE;
            res_q          <= {WIDTH{1'b0}};
            hi_q           <= {WIDTH{1'b0}};
            cout_q         <= 1'b0;
            zero_q         <= 1'b0;
            ill_q          <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            dbz_q          <= 1'b0;
`endif
        end else begin
            op_ready_q     <= (state_d == IDLE);
            result_valid_q <= (state_d == DONE);
            if (accept_s) begin
                ctrl_q <= operation_type;
            end else if (consume_s) begin
                ctrl_q <= CTRL_IDLE;
            end
            if (load_s) begin
                res_q  <= res_d;
                hi_q   <= hi_d;
                cout_q <= cout_d;
                zero_q <= zero_d;
                ill_q  <= ill_d;
`ifdef ALU_SEQ_DIV_EN
                dbz_q  <= dbz_d;
`endif
            end else if (consume_s) begin
                res_q  <= {WIDTH{1'b0}};
                hi_q   <= {WIDTH{1'b0}};
                cout_q <= 1'b0;
                zero_q <= 1'b0;
                ill_q  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
                dbz_q  <= 1'b0;
`endif
            end
        end
    end

    assign op_ready     = op_ready_q;
    assign result_valid = result_valid_q;
    assign controller   = ctrl_q;
    assign result       = res_q;
    assign result_hi    = hi_q;
    assign carry_out    = cout_q;
    assign zero         = zero_q;
    assign illegal      = ill_q;
`ifdef ALU_SEQ_DIV_EN
    assign div_by_zero  = dbz_q;
`else
    assign div_by_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer (WIDTH=4) against a cycle-level reference model.
// Divide expectations follow whether ALU_SEQ_DIV_EN is defined for the build.
module tb_alu_op_sequencer;

    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic         op_valid;
    logic         op_ready;
    logic [3:0]   operation_type;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic [3:0]   controller;
    logic         result_valid;
    logic         result_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         carry_out;
    logic         zero;
    logic         div_by_zero;
    logic         illegal;

    always #5 clock = ~clock;

    alu_op_sequencer #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .operation_type (operation_type),
        .a              (a),
        .b              (b),
        .carry_in       (carry_in),
        .controller     (controller),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result         (result),
        .result_hi      (result_hi),
        .carry_out      (carry_out),
        .zero           (zero),
        .div_by_zero    (div_by_zero),
        .illegal        (illegal)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         cout;
        logic         zero;
        logic         dbz;
        logic         ill;
        int           lat;
    } exp_t;

    // what an op must produce, from plain integer arithmetic
    function automatic exp_t model(input int op, input int x, input int y, input int cin);
        exp_t e;
        int   mask;
        int   r;
        int   h;
        mask   = (1 << W) - 1;
        r      = 0;
        h      = 0;
        e.cout = 1'b0;
        e.dbz  = 1'b0;
        e.ill  = 1'b0;
        e.lat  = 1;
        case (op)
            0: r = x & y;
            1: r = ~(x & y);
            2: r = x | y;
            3: r = ~(x | y);
            4: r = x ^ y;
            5: r = ~(x ^ y);
            6: r = ~x;
            7: begin r = x + y + cin; e.cout = (x + y + cin) > mask; end
            8: begin r = x - y - cin; e.cout = (x >= y + cin); end
            9: begin r = x * y; h = (x * y) >> W; e.lat = W + 1; end
`ifdef ALU_SEQ_DIV_EN
            10: begin
                if (y == 0) begin
                    r = mask; h = x; e.dbz = 1'b1;
                end else begin
                    r = x / y; h = x % y; e.lat = W + 1;
                end
            end
`endif
            default: e.ill = 1'b1;
        endcase
        e.res  = W'(r & mask);
        e.hi   = W'(h & mask);
        e.zero = (e.res == 0) && (e.hi == 0);
        return e;
    endfunction

    // protocol model: one op in flight, result visible lat edges after accept
    logic m_busy = 1'b0;
    int   m_cnt = 0;
    int   m_op = 0;
    int   m_accepts = 0;
    int   m_done = 0;
    exp_t m_e;
    logic chk_en = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_busy <= 1'b0;
        end else if (!m_busy) begin
            if (op_valid) begin
                m_busy    <= 1'b1;
                m_cnt     <= 0;
                m_op      <= int'(operation_type);
                m_e       <= model(int'(operation_type), int'(a), int'(b), int'(carry_in));
                m_accepts <= m_accepts + 1;
            end
        end else if (m_cnt >= m_e.lat && result_ready) begin
            m_busy <= 1'b0;
            m_done <= m_done + 1;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // compare DUT against the model every cycle, away from the active edge
    always @(negedge clock) begin
        if (chk_en) begin
            if (m_busy) begin
                check("op_ready_busy", op_ready, 1'b0);
                check("controller", controller, m_op);
                check("result_valid", result_valid, m_cnt >= m_e.lat);
                if (m_cnt >= m_e.lat) begin
                    check("result", result, m_e.res);
                    check("result_hi", result_hi, m_e.hi);
                    check("carry_out", carry_out, m_e.cout);
                    check("zero", zero, m_e.zero);
                    check("div_by_zero", div_by_zero, m_e.dbz);
                    check("illegal", illegal, m_e.ill);
                end
            end else begin
                check("op_ready_idle", op_ready, 1'b1);
                check("result_valid_idle", result_valid, 1'b0);
                check("controller_idle", controller, 4'b0000);
            end
        end
    end

    // one transaction; hold>0 keeps result_ready low for hold cycles while op_valid nags
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic cin, input int hold);
        int acc0;
        int done0;
        int t;
        acc0  = m_accepts;
        done0 = m_done;
        operation_type = op; a = x; b = y; carry_in = cin;
        op_valid = 1'b1;
        result_ready = (hold == 0);
        t = 0;
        while (m_accepts == acc0 && t < 50) begin @(negedge clock); t++; end
        check("accept_timeout", m_accepts != acc0, 1'b1);
        a = W'($urandom); b = W'($urandom); operation_type = 4'($urandom); carry_in = 1'($urandom);
        op_valid = (hold > 0);
        if (hold > 0) begin
            t = 0;
            while (!(m_busy && m_cnt >= m_e.lat) && t < 50) begin @(negedge clock); t++; end
            repeat (hold) @(negedge clock);
            op_valid = 1'b0;
            result_ready = 1'b1;
        end
        t = 0;
        while (m_done == done0 && t < 50) begin @(negedge clock); t++; end
        check("result_timeout", m_done != done0, 1'b1);
        result_ready = 1'b0;
    endtask

    exp_t e;

    initial begin
        reset = 1'b1; op_valid = 1'b0; result_ready = 1'b0;
        operation_type = 4'b0000; a = '0; b = '0; carry_in = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_op_ready", op_ready, 1'b1);
        check("rst_result_valid", result_valid, 1'b0);
        check("rst_controller", controller, 4'b0000);
        check("rst_result", {result_hi, result}, 8'h00);
        check("rst_flags", {carry_out, zero, div_by_zero, illegal}, 4'b0000);
        reset = 1'b0;
        chk_en = 1'b1;

        e = model(0, 4'b1010, 4'b0101, 0);
        check("pin_and", {e.res, 3'(e.lat), e.zero}, {4'b0000, 3'd1, 1'b1});
        e = model(7, 4'b0011, 4'b0001, 0);
        check("pin_add", {e.res, e.cout}, {4'b0100, 1'b0});
        e = model(7, 4'b1111, 4'b0001, 0);
        check("pin_add_wrap", {e.res, e.cout, e.zero}, {4'b0000, 1'b1, 1'b1});
        e = model(8, 4'b0100, 4'b0010, 0);
        check("pin_sub", {e.res, e.cout}, {4'b0010, 1'b1});
        e = model(9, 4'b0011, 4'b0010, 0);
        check("pin_mul", {e.hi, e.res, 3'(e.lat)}, {4'b0000, 4'b0110, 3'd5});
        e = model(9, 4'b1111, 4'b1111, 0);
        check("pin_mul_max", {e.hi, e.res}, {4'b1110, 4'b0001});
        e = model(12, 4'b0001, 4'b0001, 0);
        check("pin_illegal", {e.ill, e.zero, e.res, e.hi}, {1'b1, 1'b1, 8'h00});
`ifdef ALU_SEQ_DIV_EN
        e = model(10, 4'b0100, 4'b0010, 0);
        check("pin_div", {e.res, e.hi, 3'(e.lat)}, {4'b0010, 4'b0000, 3'd5});
        e = model(10, 4'b0111, 4'b0000, 0);
        check("pin_div0", {e.res, e.hi, e.dbz, 3'(e.lat)}, {4'b1111, 4'b0111, 1'b1, 3'd1});
`else
        e = model(10, 4'b0100, 4'b0010, 0);
        check("pin_div_illegal", {e.ill, e.dbz}, {1'b1, 1'b0});
`endif

        run_op(4'b0000, 4'b1010, 4'b0101, 1'b0, 0);
        run_op(4'b0111, 4'b0011, 4'b0001, 1'b0, 0);
        run_op(4'b0111, 4'b1111, 4'b0001, 1'b0, 0);
        run_op(4'b1000, 4'b0100, 4'b0010, 1'b0, 0);
        run_op(4'b1001, 4'b0011, 4'b0010, 1'b0, 0);
        run_op(4'b1001, 4'b1111, 4'b1111, 1'b0, 0);
        run_op(4'b1010, 4'b0100, 4'b0010, 1'b0, 0);
        run_op(4'b1010, 4'b0111, 4'b0000, 1'b0, 0);
        run_op(4'b1100, 4'b0101, 4'b0011, 1'b0, 0);
        run_op(4'b1001, 4'b1011, 4'b0111, 1'b0, 4);

        // reset during the second ITER cycle of a MUL: dropped, no result
        operation_type = 4'b1001; a = 4'b1101; b = 4'b0110; carry_in = 1'b0;
        op_valid = 1'b1; result_ready = 1'b1;
        @(negedge clock);
        op_valid = 1'b0;
        check("mul_accepted", m_busy, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("reset_drop_valid", result_valid, 1'b0);
        check("reset_drop_ready", op_ready, 1'b1);
        repeat (6) @(negedge clock);
        run_op(4'b0111, 4'b0101, 4'b0110, 1'b1, 0);

        // randomized traffic, including busy-time requests, stalls and stray resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            op_valid       = 1'($urandom_range(0, 1));
            operation_type = 4'($urandom_range(0, 15));
            a              = W'($urandom);
            b              = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            carry_in       = 1'($urandom);
            result_ready   = ($urandom_range(0, 2) != 0);
            reset          = ($urandom_range(0, 199) == 0);
        end
        @(negedge clock);
        reset = 1'b0; op_valid = 1'b0; result_ready = 1'b1;
        repeat (20) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
